// File: rtl/block_dispatch_cu_if.sv
// rtl/block_dispatch_cu_if.sv - job/memory/processor handshake bundle for block_dispatch_cu
interface block_dispatch_cu_if #(
    parameter int P       = 4,
    parameter int INDEX_W = 8,
    parameter int ADDR_W  = 10
);
    logic               i_Data_Ready;
    logic               o_Grant_Request;
    logic               i_Grant;
    logic [ADDR_W-1:0]  o_Mem_Address;
    logic               o_Mem_Write_En;
    logic [31:0]        o_Mem_Wdata;
    logic [31:0]        i_Mem_Rdata;
    logic [INDEX_W-1:0] o_Row_Index;
    logic [INDEX_W-1:0] o_Column_Index;
    logic [P-1:0]       o_Indexes_Ready;
    logic [P-1:0]       i_Indexes_Recv;
    logic [P-1:0]       i_Result_Ready;
    logic               o_Busy;
    logic               o_Done;

    // Control unit side
    modport master (
        input  i_Data_Ready, i_Grant, i_Mem_Rdata, i_Indexes_Recv, i_Result_Ready,
        output o_Grant_Request, o_Mem_Address, o_Mem_Write_En, o_Mem_Wdata,
               o_Row_Index, o_Column_Index, o_Indexes_Ready, o_Busy, o_Done
    );

    // Memory, arbiter and processor side
    modport slave (
        output i_Data_Ready, i_Grant, i_Mem_Rdata, i_Indexes_Recv, i_Result_Ready,
        input  o_Grant_Request, o_Mem_Address, o_Mem_Write_En, o_Mem_Wdata,
               o_Row_Index, o_Column_Index, o_Indexes_Ready, o_Busy, o_Done
    );
endinterface

// File: rtl/block_dispatch_cu.sv
// rtl/block_dispatch_cu.sv - matrix job controller scattering block indexes over P processors; optional watchdog via DISPATCH_TIMEOUT_EN
module block_dispatch_cu #(
    parameter int P           = 4,
    parameter int INDEX_W     = 8,
    parameter int GREEK_W     = 8,
    parameter int ADDR_W      = 10,
    parameter int CFG_ADDR    = 0,
    parameter int STATUS_ADDR = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    block_dispatch_cu_if.master  bus
);
    localparam int KW = $clog2(P + 1);
    localparam int NW = 2 * GREEK_W;
    localparam int CW = ((INDEX_W > GREEK_W) ? INDEX_W : GREEK_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ_CFG, S_RD_CFG, S_DISPATCH, S_WAIT_RES, S_REQ_STS, S_RD_STS, S_WR_STS
    } state_t;

    state_t             state_q;
    logic               armed_q, phase_q, err_q, tmo_q;
    logic [GREEK_W-1:0] gamma_q;
    logic [NW-1:0]      rem_q;
    logic [KW-1:0]      k_q;
    logic [INDEX_W-1:0] row_q, col_q;
    logic [P-1:0]       sent_q, got_q, valid_q;
    logic               req_q, we_q, busy_q, done_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
`ifdef DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]      tmo_cnt_q;
`endif

    logic [GREEK_W-1:0] cfg_gamma, cfg_lambda;
    logic [NW-1:0]      cfg_n;
    logic               ack_hit, last_ack, row_wrap;
    logic [P-1:0]       sent_acc, got_acc;

    assign cfg_lambda = bus.i_Mem_Rdata[GREEK_W-1:0];
    assign cfg_gamma  = bus.i_Mem_Rdata[2*GREEK_W-1:GREEK_W];
    assign cfg_n      = NW'(cfg_gamma) * NW'(cfg_lambda);

    // Ack only counts on the processor currently offered indexes; results are masked by what was sent,
    // including a processor acked in this very cycle
    assign ack_hit  = (valid_q & bus.i_Indexes_Recv) != '0;
    assign last_ack = ((k_q + KW'(1)) == KW'(P)) || (rem_q == NW'(1));
    assign row_wrap = (CW'(row_q) + CW'(1)) == CW'(gamma_q);
    assign sent_acc = ack_hit ? (sent_q | valid_q) : sent_q;
    assign got_acc  = got_q | (bus.i_Result_Ready & sent_acc);

    assign bus.o_Grant_Request = req_q;
    assign bus.o_Mem_Address   = addr_q;
    assign bus.o_Mem_Write_En  = we_q;
    assign bus.o_Mem_Wdata     = wdata_q;
    assign bus.o_Row_Index     = row_q;
    assign bus.o_Column_Index  = col_q;
    assign bus.o_Indexes_Ready = valid_q;
    assign bus.o_Busy          = busy_q;
    assign bus.o_Done          = done_q;

    // Job sequencing: config read, dispatch rounds, result barrier, status read-modify-write
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= S_IDLE;
            armed_q <= 1'b1;
            phase_q <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            gamma_q <= '0;
            rem_q   <= '0;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            sent_q  <= '0;
            got_q   <= '0;
            valid_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DISPATCH_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            if (!bus.i_Data_Ready) armed_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.i_Data_Ready && armed_q) begin
                        armed_q <= 1'b0;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
                        err_q   <= 1'b0;
                        tmo_q   <= 1'b0;
                        state_q <= S_REQ_CFG;
                    end
                end
                S_REQ_CFG: begin
                    req_q <= 1'b1;
                    if (req_q && bus.i_Grant) begin
                        addr_q  <= ADDR_W'(CFG_ADDR);
                        phase_q <= 1'b0;
                        state_q <= S_RD_CFG;
                    end
                end
                S_RD_CFG: begin
                    if (!bus.i_Grant) begin
                        phase_q <= 1'b0;
                        state_q <= S_REQ_CFG;
                    end else if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        req_q   <= 1'b0;
                        gamma_q <= cfg_gamma;
                        if (cfg_n == '0) begin
                            err_q   <= 1'b1;
                            state_q <= S_REQ_STS;
                        end else begin
                            row_q   <= '0;
                            col_q   <= '0;
                            rem_q   <= cfg_n;
                            k_q     <= '0;
                            sent_q  <= '0;
                            got_q   <= '0;
                            valid_q <= P'(1);
                            state_q <= S_DISPATCH;
                        end
                    end
                end
                S_DISPATCH: begin
                    got_q <= got_acc;
                    if (ack_hit) begin
                        sent_q <= sent_acc;
                        rem_q  <= rem_q - NW'(1);
                        k_q    <= k_q + KW'(1);
                        if (row_wrap) begin
                            row_q <= '0;
                            col_q <= col_q + INDEX_W'(1);
                        end else begin
                            row_q <= row_q + INDEX_W'(1);
                        end
                        if (last_ack) begin
                            valid_q <= '0;
                            state_q <= S_WAIT_RES;
`ifdef DISPATCH_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end else begin
                            valid_q <= valid_q << 1;
                        end
                    end
                end
                S_WAIT_RES: begin
                    if (got_acc == sent_q) begin
                        got_q  <= '0;
                        sent_q <= '0;
                        k_q    <= '0;
                        if (rem_q != '0) begin
                            valid_q <= P'(1);
                            state_q <= S_DISPATCH;
                        end else begin
                            state_q <= S_REQ_STS;
                        end
                    end else begin
                        got_q <= got_acc;
`ifdef DISPATCH_TIMEOUT_EN
                        if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                            tmo_q   <= 1'b1;
                            rem_q   <= '0;
                            got_q   <= '0;
                            sent_q  <= '0;
                            k_q     <= '0;
                            state_q <= S_REQ_STS;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TW'(1);
                        end
`endif
                    end
                end
                S_REQ_STS: begin
                    req_q <= 1'b1;
                    if (req_q && bus.i_Grant) begin
                        addr_q  <= ADDR_W'(STATUS_ADDR);
                        phase_q <= 1'b0;
                        state_q <= S_RD_STS;
                    end
                end
                S_RD_STS: begin
                    if (!bus.i_Grant) begin
                        phase_q <= 1'b0;
                        state_q <= S_REQ_STS;
                    end else if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        wdata_q <= bus.i_Mem_Rdata | {29'b0, tmo_q, err_q, 1'b1};
                        we_q    <= 1'b1;
                        state_q <= S_WR_STS;
                    end
                end
                S_WR_STS: begin
                    we_q    <= 1'b0;
                    req_q   <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_dispatch_cu.sv
// tb/tb_block_dispatch_cu.sv - randomized bench for block_dispatch_cu against a job-level reference model
module tb_block_dispatch_cu;
    localparam int P       = 4;
    localparam int INDEX_W = 8;
    localparam int GREEK_W = 8;
    localparam int ADDR_W  = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    block_dispatch_cu_if #(.P(P), .INDEX_W(INDEX_W), .ADDR_W(ADDR_W)) bus ();

    block_dispatch_cu #(
        .P(P), .INDEX_W(INDEX_W), .GREEK_W(GREEK_W), .ADDR_W(ADDR_W),
        .CFG_ADDR(0), .STATUS_ADDR(1), .TIMEOUT_CYC(4096)
    ) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference job parameters, set by the main sequence before each job
    logic [31:0] cfg_word, sts_word;
    int job_g, job_n, job_base, res_base;
    logic run;

    // Monitor-owned counters
    int disp_cnt = 0, delivered = 0, done_cnt = 0, wr_cnt = 0;
    logic [31:0] last_wdata;
    logic [ADDR_W-1:0] last_waddr;
    int pend [P];

    // Memory: one-cycle registered read, so data is valid on the second edge after the address
    always @(posedge clk)
        bus.i_Mem_Rdata <= (bus.o_Mem_Address == ADDR_W'(0)) ? cfg_word :
                           (bus.o_Mem_Address == ADDR_W'(1)) ? sts_word : 32'hdead_beef;

    // Arbiter, processors and dispatch scoreboard
    always @(negedge clk) begin
        logic [P-1:0] recv, res, hit;
        int i, k, gg;
        if (!run) begin
            bus.i_Grant = 1'b0;
            bus.i_Indexes_Recv = '0;
            bus.i_Result_Ready = '0;
            for (int j = 0; j < P; j++) pend[j] = -1;
        end else begin
            if (bus.o_Mem_Write_En) begin
                wr_cnt++;
                last_wdata = bus.o_Mem_Wdata;
                last_waddr = bus.o_Mem_Address;
            end
            if (bus.o_Done) done_cnt++;
            bus.i_Grant = bus.o_Grant_Request && ($urandom_range(0, 4) != 0);
            res = '0;
            for (int j = 0; j < P; j++) begin
                if (pend[j] == 0) begin
                    res[j] = 1'b1;
                    pend[j] = -1;
                    delivered++;
                end else if (pend[j] > 0) begin
                    pend[j]--;
                end
            end
            bus.i_Result_Ready = res;
            recv = P'($urandom) & P'($urandom);
            bus.i_Indexes_Recv = recv;
            hit = bus.o_Indexes_Ready & recv;
            if (hit != '0) begin
                k = 0;
                for (int j = P - 1; j >= 0; j--) if (hit[j]) k = j;
                i  = disp_cnt - job_base;
                gg = (job_g == 0) ? 1 : job_g;
                check_eq("dispatch_proc_row_col",
                         {32'(k), 16'(bus.o_Row_Index), 16'(bus.o_Column_Index)},
                         {32'(i % P), 16'(i % gg), 16'(i / gg)});
                if (i % P == 0 && i > 0)
                    check_eq("round_barrier", 64'(delivered - res_base), 64'(i));
                pend[k] = $urandom_range(0, 6);
                disp_cnt++;
            end
        end
    end

    task automatic run_job(input int g, input int l);
        int done_base, wr_base, busy_again;
        bit seen;
        logic [31:0] exp_sts;
        cfg_word = $urandom;
        cfg_word[15:0] = {8'(g), 8'(l)};
        sts_word = $urandom;
        job_g    = g;
        job_n    = g * l;
        job_base = disp_cnt;
        res_base = delivered;
        done_base = done_cnt;
        wr_base  = wr_cnt;
        @(negedge clk);
        bus.i_Data_Ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(negedge clk);
            if (done_cnt != done_base) seen = 1'b1;
        end
        check_eq("job_completes", 64'(seen), 64'(1));
        busy_again = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_Busy) busy_again++;
        end
        exp_sts = sts_word | {29'b0, 1'b0, (job_n == 0), 1'b1};
        check_eq("no_rerun_while_held", 64'(busy_again), 64'(0));
        check_eq("done_pulses", 64'(done_cnt - done_base), 64'(1));
        check_eq("status_writes", 64'(wr_cnt - wr_base), 64'(1));
        check_eq("status_addr", 64'(last_waddr), 64'(1));
        check_eq("status_data", 64'(last_wdata), 64'(exp_sts));
        check_eq("dispatch_count", 64'(disp_cnt - job_base), 64'(job_n));
        check_eq("results_count", 64'(delivered - res_base), 64'(job_n));
        bus.i_Data_Ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int gl [8][2] = '{'{2, 3}, '{0, 5}, '{3, 0}, '{1, 1}, '{4, 2}, '{5, 3}, '{1, 6}, '{6, 1}};
        run = 1'b0;
        rst_n = 1'b0;
        bus.i_Data_Ready = 1'b0;
        cfg_word = '0;
        sts_word = '0;
        job_g = 0; job_n = 0; job_base = 0; res_base = 0;
        repeat (3) @(negedge clk);
        check_eq("reset_grant_req", 64'(bus.o_Grant_Request), 64'(0));
        check_eq("reset_busy", 64'(bus.o_Busy), 64'(0));
        check_eq("reset_done", 64'(bus.o_Done), 64'(0));
        check_eq("reset_valid", 64'(bus.o_Indexes_Ready), 64'(0));
        check_eq("reset_we", 64'(bus.o_Mem_Write_En), 64'(0));
        rst_n = 1'b1;
        run = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 8; t++) run_job(gl[t][0], gl[t][1]);
        for (int t = 0; t < 6; t++) run_job($urandom_range(0, 6), $urandom_range(0, 6));

        // Asynchronous reset in the middle of a job releases the bus at once
        run_job(0, 0);
        cfg_word = 32'h0000_0404;
        job_g = 4; job_n = 16; job_base = disp_cnt; res_base = delivered;
        @(negedge clk);
        bus.i_Data_Ready = 1'b1;
        repeat (12) @(negedge clk);
        #2;
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        check_eq("async_reset_grant_req", 64'(bus.o_Grant_Request), 64'(0));
        check_eq("async_reset_busy", 64'(bus.o_Busy), 64'(0));
        check_eq("async_reset_valid", 64'(bus.o_Indexes_Ready), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
